baccarat_datapath: RTL and testbench
====================================

# baccarat_datapath

Card-dealing datapath for the baccarat game, sitting opposite the game `statemachine`. It consumes the six `load_*` strobes, deals one card per strobe from an internal card source, and holds the three player and three dealer cards. It returns `pscore`, `dscore` and `pcard3`, which close the loop back into the state machine, and exposes the cards for display.

## Interface
Parameters: none.

All outputs reset to 0.

- `slow_clock` in 1 — sole clock, rising edge.
- `resetb` in 1 — asynchronous, active-low reset.
- `load_pcard1`, `load_pcard2`, `load_pcard3` in 1 each — deal the current card into player slot 1/2/3.
- `load_dcard1`, `load_dcard2`, `load_dcard3` in 1 each — deal the current card into dealer slot 1/2/3.
- `pcard1`, `pcard2`, `pcard3` out 4 each — player card ranks; 0 = empty, 1..13 = A..K. `pcard3` also feeds the state machine.
- `dcard1`, `dcard2`, `dcard3` out 4 each — dealer card ranks, same encoding.
- `pscore`, `dscore` out 4 — hand scores, 0..9.
- `card_count` out 3 — number of successful deals, 0..6.
- `deal_err` out 1 — sticky protocol-error flag.

## Operation
**Card source.** A register `src` advances on every rising edge, whether or not a load is active.
- Default mode is a counter: reset value 1, sequence 1, 2, …, 13, then wraps to 1.
- A load captures the card value *before* that edge's advance.

**Card value.**
- Ranks 1..9 score at face value.
- Ranks 10..13 and empty (0) score 0.

**Score.**
- `pscore = (val(pcard1) + val(pcard2) + val(pcard3)) mod 10`. Use a 5-bit intermediate sum; the maximum is 27, which gives a score of 7.
- `dscore` is computed the same way from the dealer cards.
- Scores are combinational from the card registers.

**Load rules**, evaluated per edge:
- Exactly one strobe high and the target slot empty: store the card in the slot and increment `card_count`.
- More than one strobe high in the same cycle: no slot changes, `card_count` holds, `deal_err` is set to 1.
- Single strobe to a non-empty slot: the slot keeps its old value, `card_count` holds, `deal_err` is set to 1.
- Out-of-order slot loading (for example `pcard2` before `pcard1`) is legal.
- `card_count` saturates at 6. It cannot exceed 6 given the rules above.

**Error flag.** `deal_err` stays at 1 until reset. It does not block later legal loads.

**Reset.**
- `resetb` low asynchronously clears all cards, `card_count`, `deal_err` and `src`, even mid-hand.
- While `resetb` is low, strobes are ignored.

## Timing
- **Load latency:** a strobe sampled at edge N makes the card visible on `pcardX`/`dcardX` after edge N.
- **Score latency:** `pscore`/`dscore` update in the same cycle, so the state machine sees the new score at edge N+1.
- **Strobe duration:** strobes are single-cycle. A strobe held for two cycles is a reload and sets `deal_err`.
- **Card source after reset:** in counter mode, the first edge after `resetb` rises deals 1, and the k-th edge deals ((k−1) mod 13)+1.
- **No internal handshakes:** there is no ready/valid signalling; the state machine owns all sequencing.

## Configuration
`BACCARAT_LFSR_EN` selects the card source.
- **Defined:** `src` is a 6-bit Fibonacci LFSR with polynomial x^6+x^5+1.
  - Shift left; the new bit 0 is bit5 XOR bit4.
  - Reset seed is 6'h01.
  - Dealt card = (lfsr mod 13) + 1, so the first card after reset is 2.
  - The all-zero state is unreachable.
- **Undefined:** the 1..13 counter described under Operation.
- Ports, latency and load rules are identical in both modes.

## Test plan
All scenarios use counter mode unless noted.

1. **Basic deal:** reset, then pulse `load_pcard1` at edge 1, `load_dcard1` at edge 2, `load_pcard2` at edge 3 → `pcard1`=1, `dcard1`=2, `pcard2`=3, `pscore`=4, `dscore`=2, `card_count`=3, `deal_err`=0.
2. **Face card and modulo:** reset, then load `pcard1` at edge 10 → `pcard1`=10, `pscore`=0. Load `pcard2` at edge 22 and `pcard3` at edge 35 → both are 9, `pscore`=(0+9+9) mod 10=8.
3. **Maximum sum:** reset, then load `dcard1`/`dcard2`/`dcard3` at edges 9/22/35 → all three are 9, `dscore`=7.
4. **Errors:**
   - `load_pcard1` and `load_dcard1` high at the same edge → both slots stay 0, `card_count`=0, `deal_err`=1.
   - A later `load_pcard1` alone succeeds; `deal_err` stays 1.
   - Reloading `pcard1` → value unchanged, `deal_err` stays 1.
5. **Reset mid-hand:** after scenario 1, drop `resetb` between edges → all outputs read 0 immediately without a clock. Release reset and load `pcard1` at the next edge → `pcard1`=1.
6. **LFSR build** (with `BACCARAT_LFSR_EN`): reset, then load `pcard1` at edge 1 → `pcard1`=2. Over 63 consecutive edges every rank stays within 1..13, and the card sequence repeats with period 63.

Source files
------------

// File: rtl/baccarat_datapath.sv
// baccarat_datapath: deals one card per load strobe into six slots and scores both hands.
// Card source is a 1..13 counter; defining BACCARAT_LFSR_EN swaps in a 6-bit LFSR.
`default_nettype none

module baccarat_datapath (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] card_count,
  output logic       deal_err
);

  localparam logic [2:0] MAX_CARDS = 3'd6;

  logic [5:0] load_vec;
  logic [3:0] card_q [6];
  logic [3:0] card_d [6];
  logic [2:0] count_q, count_d;
  logic       err_q, err_d;
  logic [3:0] deal_card;
  logic [2:0] n_strobes;
  logic [2:0] sel;

`ifdef BACCARAT_LFSR_EN
  localparam logic [5:0] SRC_RESET = 6'h01;
  logic [5:0] src_q, src_d;

  always_comb begin
    src_d     = {src_q[4:0], src_q[5] ^ src_q[4]};
    deal_card = 4'(src_q % 6'd13) + 4'd1;
  end
`else
  localparam logic [3:0] SRC_RESET = 4'd1;
  logic [3:0] src_q, src_d;

  always_comb begin
    src_d     = (src_q == 4'd13) ? 4'd1 : src_q + 4'd1;
    deal_card = src_q;
  end
`endif

  assign load_vec = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

  // sel is only meaningful when exactly one strobe is high
  always_comb begin
    n_strobes = '0;
    sel       = '0;
    for (int i = 0; i < 6; i++) begin
      if (load_vec[i]) begin
        n_strobes = n_strobes + 3'd1;
        sel       = 3'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) card_d[i] = card_q[i];
    count_d = count_q;
    err_d   = err_q;
    if (n_strobes > 3'd1) begin
      err_d = 1'b1;
    end else if (n_strobes == 3'd1) begin
      if (card_q[sel] == 4'd0) begin
        card_d[sel] = deal_card;
        if (count_q != MAX_CARDS) count_d = count_q + 3'd1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      src_q   <= SRC_RESET;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 6; i++) card_q[i] <= '0;
    end else begin
      src_q   <= src_d;
      count_q <= count_d;
      err_q   <= err_d;
      for (int i = 0; i < 6; i++) card_q[i] <= card_d[i];
    end
  end

  function automatic logic [3:0] card_val(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] sum;
    sum = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
    return 4'(sum % 5'd10);
  endfunction

  assign pcard1     = card_q[0];
  assign pcard2     = card_q[1];
  assign pcard3     = card_q[2];
  assign dcard1     = card_q[3];
  assign dcard2     = card_q[4];
  assign dcard3     = card_q[5];
  assign pscore     = hand_score(card_q[0], card_q[1], card_q[2]);
  assign dscore     = hand_score(card_q[3], card_q[4], card_q[5]);
  assign card_count = count_q;
  assign deal_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_baccarat_datapath.sv
// tb_baccarat_datapath: directed scenarios plus randomized hands against a card-sequence model.
`default_nettype none

module tb_baccarat_datapath;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
  logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic [2:0] card_count;
  logic       deal_err;

  baccarat_datapath dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .load_pcard1(load_pcard1),
    .load_pcard2(load_pcard2),
    .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1),
    .load_dcard2(load_dcard2),
    .load_dcard3(load_dcard3),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .card_count (card_count),
    .deal_err   (deal_err)
  );

  always #5 slow_clock = ~slow_clock;

  localparam logic [5:0] P1 = 6'b000001, P2 = 6'b000010, P3 = 6'b000100;
  localparam logic [5:0] D1 = 6'b001000, D2 = 6'b010000, D3 = 6'b100000;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: slot order p1,p2,p3,d1,d2,d3
  int mslot [6];
  int mcount, merr, medge, mlfsr;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_card();
`ifdef BACCARAT_LFSR_EN
    return (mlfsr % 13) + 1;
`else
    return (medge % 13) + 1;
`endif
  endfunction

  function automatic int score(input int a, input int b, input int c);
    int s;
    s = 0;
    if (a >= 1 && a <= 9) s += a;
    if (b >= 1 && b <= 9) s += b;
    if (c >= 1 && c <= 9) s += c;
    return s % 10;
  endfunction

  task automatic model_reset();
    foreach (mslot[i]) mslot[i] = 0;
    mcount = 0; merr = 0; medge = 0; mlfsr = 1;
  endtask

  task automatic model_edge(input logic [5:0] s);
    int n, idx, card;
    n = 0; idx = 0;
    for (int i = 0; i < 6; i++) if (s[i]) begin n++; idx = i; end
    card = model_card();
    if (n > 1) merr = 1;
    else if (n == 1) begin
      if (mslot[idx] == 0) begin mslot[idx] = card; mcount++; end
      else merr = 1;
    end
    medge++;
    mlfsr = ((mlfsr << 1) & 63) | (((mlfsr >> 5) ^ (mlfsr >> 4)) & 1);
  endtask

  task automatic check_all();
    check_val("pcard1", int'(pcard1), mslot[0]);
    check_val("pcard2", int'(pcard2), mslot[1]);
    check_val("pcard3", int'(pcard3), mslot[2]);
    check_val("dcard1", int'(dcard1), mslot[3]);
    check_val("dcard2", int'(dcard2), mslot[4]);
    check_val("dcard3", int'(dcard3), mslot[5]);
    check_val("pscore", int'(pscore), score(mslot[0], mslot[1], mslot[2]));
    check_val("dscore", int'(dscore), score(mslot[3], mslot[4], mslot[5]));
    check_val("card_count", int'(card_count), mcount);
    check_val("deal_err", int'(deal_err), merr);
  endtask

  task automatic drive(input logic [5:0] s);
    {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = s;
  endtask

  // Every task below is entered and left at a falling edge.
  task automatic cycle(input logic [5:0] s);
    drive(s);
    @(posedge slow_clock);
    model_edge(s);
    #1;
    check_all();
    @(negedge slow_clock);
    drive(6'b0);
  endtask

  task automatic idle_to(input int edge_n);
    while (medge < edge_n - 1) cycle(6'b0);
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    drive(6'($urandom));
    #1;
    model_reset();
    check_all();
    @(posedge slow_clock);
    #1;
    check_all();
    @(negedge slow_clock);
    drive(6'b0);
    resetb = 1'b1;
  endtask

  function automatic logic [5:0] rand_strobes();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 65) return 6'b0;
    if (r < 93) return 6'b1 << $urandom_range(0, 5);
    return 6'($urandom);
  endfunction

  initial begin
    model_reset();
    @(negedge slow_clock);

    // basic deal, then reset mid-hand
    do_reset();
    cycle(P1); cycle(D1); cycle(P2);
`ifndef BACCARAT_LFSR_EN
    check_val("s1_pcard1", int'(pcard1), 1);
    check_val("s1_dcard1", int'(dcard1), 2);
    check_val("s1_pcard2", int'(pcard2), 3);
    check_val("s1_pscore", int'(pscore), 4);
    check_val("s1_dscore", int'(dscore), 2);
    check_val("s1_count", int'(card_count), 3);
    check_val("s1_err", int'(deal_err), 0);
`endif
    #2;
    resetb = 1'b0;
    #1;
    check_val("s5_async_pcard1", int'(pcard1), 0);
    check_val("s5_async_count", int'(card_count), 0);
    check_val("s5_async_pscore", int'(pscore), 0);
    @(negedge slow_clock);
    do_reset();
    cycle(P1);
`ifndef BACCARAT_LFSR_EN
    check_val("s5_pcard1", int'(pcard1), 1);
`else
    check_val("lfsr_first", int'(pcard1), 2);
`endif

`ifndef BACCARAT_LFSR_EN
    // face card and modulo
    do_reset();
    idle_to(10); cycle(P1);
    check_val("s2_pcard1", int'(pcard1), 10);
    check_val("s2_pscore0", int'(pscore), 0);
    idle_to(22); cycle(P2);
    idle_to(35); cycle(P3);
    check_val("s2_pcard3", int'(pcard3), 9);
    check_val("s2_pscore", int'(pscore), 8);

    // maximum sum
    do_reset();
    idle_to(9);  cycle(D1);
    idle_to(22); cycle(D2);
    idle_to(35); cycle(D3);
    check_val("s3_dcard3", int'(dcard3), 9);
    check_val("s3_dscore", int'(dscore), 7);
`endif

    // protocol errors
    do_reset();
    cycle(P1 | D1);
    check_val("s4_multi_p1", int'(pcard1), 0);
    check_val("s4_multi_count", int'(card_count), 0);
    check_val("s4_multi_err", int'(deal_err), 1);
    cycle(P1);
    check_val("s4_after_count", int'(card_count), 1);
    check_val("s4_after_err", int'(deal_err), 1);
    cycle(P1);
    cycle(D2); cycle(D2);
`ifndef BACCARAT_LFSR_EN
    check_val("s4_reload_p1", int'(pcard1), 2);
    check_val("s4_held_d2", int'(dcard2), 4);
`endif

`ifdef BACCARAT_LFSR_EN
    // period-63 check: card dealt at edge m+1 must recur at edge m+64
    for (int m = 0; m < 63; m++) begin
      int first;
      do_reset();
      idle_to(m + 1); cycle(P1);
      check_val("lfsr_range", int'(pcard1 >= 4'd1 && pcard1 <= 4'd13), 1);
      first = mslot[0];
      do_reset();
      idle_to(m + 64); cycle(P1);
      check_val("lfsr_period", int'(pcard1), first);
    end
`endif

    // randomized hands
    for (int h = 0; h < 30; h++) begin
      do_reset();
      for (int c = 0; c < 40; c++) cycle(rand_strobes());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
